// File: rtl/traffic_input_conditioner.sv
// Input front end for the traffic controller: one-second enable, two-flop synchronizers,
// debounce FSMs for the walk button and side-street sensor, and a sticky walk request.

module tic_debounce #(
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic sync,
    output logic deb,
    output logic rise
);
    // state | meaning
    // ------+-------------------------------------------------
    // 2'b00 | STABLE_LO: debounced level low, waiting for a 1
    // 2'b01 | CHECK_HI : low, counting consecutive 1 samples
    // 2'b10 | STABLE_HI: debounced level high, waiting for a 0
    // 2'b11 | CHECK_LO : high, counting consecutive 0 samples
    localparam int CW = $clog2(DB_CYCLES + 1);

    typedef enum logic [1:0] {
        STABLE_LO = 2'b00,
        CHECK_HI  = 2'b01,
        STABLE_HI = 2'b10,
        CHECK_LO  = 2'b11
    } db_state_t;

    db_state_t       state, state_next;
    logic [CW-1:0]   count, count_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= STABLE_LO;
            count <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    always_comb begin
        state_next = state;
        count_next = count;
        unique case (state)
            STABLE_LO: if (sync) begin
                state_next = CHECK_HI;
                count_next = CW'(1);
            end
            CHECK_HI: begin
                if (!sync) begin
                    state_next = STABLE_LO;
                    count_next = '0;
                end else if (count == CW'(DB_CYCLES)) begin
                    state_next = STABLE_HI;
                    count_next = '0;
                end else begin
                    count_next = count + CW'(1);
                end
            end
            STABLE_HI: if (!sync) begin
                state_next = CHECK_LO;
                count_next = CW'(1);
            end
            CHECK_LO: begin
                if (sync) begin
                    state_next = STABLE_HI;
                    count_next = '0;
                end else if (count == CW'(DB_CYCLES)) begin
                    state_next = STABLE_LO;
                    count_next = '0;
                end else begin
                    count_next = count + CW'(1);
                end
            end
            default: begin
                state_next = STABLE_LO;
                count_next = '0;
            end
        endcase
    end

    // The state MSB is the debounced level, so deb is a flop output with no extra stage.
    always_comb begin
        deb  = state[1];
        rise = state_next[1] & ~state[1];
    end
endmodule

module traffic_input_conditioner #(
    parameter int TICK_DIV  = 100_000_000,
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic req_raw,
    input  logic ss_raw,
    input  logic wr_ack,
    output logic sec_tick,
    output logic req_pulse,
    output logic req_pending,
    output logic ss_level
);
    localparam int TW = $clog2(TICK_DIV);

    logic [TW-1:0] cnt;
    logic          req_sync1, req_sync2;
    logic          ss_sync1, ss_sync2;
    logic          deb_req, deb_ss;
    logic          req_rise, ss_rise;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (cnt == TW'(TICK_DIV - 1)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + TW'(1);
        end
    end

    assign sec_tick = (cnt == TW'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            req_sync1 <= 1'b0;
            req_sync2 <= 1'b0;
            ss_sync1  <= 1'b0;
            ss_sync2  <= 1'b0;
        end else begin
            req_sync1 <= req_raw;
            req_sync2 <= req_sync1;
            ss_sync1  <= ss_raw;
            ss_sync2  <= ss_sync1;
        end
    end

    tic_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_req (
        .clk   (clk),
        .reset (reset),
        .sync  (req_sync2),
        .deb   (deb_req),
        .rise  (req_rise)
    );

    tic_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_ss (
        .clk   (clk),
        .reset (reset),
        .sync  (ss_sync2),
        .deb   (deb_ss),
        .rise  (ss_rise)
    );

    assign ss_level = deb_ss;

    // The pulse is registered on the same edge that raises deb_req; a set beats a
    // same-cycle acknowledge so a fresh press is never dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            req_pulse   <= 1'b0;
            req_pending <= 1'b0;
        end else begin
            req_pulse <= req_rise;
            if (req_pulse) begin
                req_pending <= 1'b1;
            end else if (wr_ack) begin
                req_pending <= 1'b0;
            end
        end
    end

    logic unused_ss_rise;
    assign unused_ss_rise = ss_rise;
endmodule
